// File: rtl/tinymips_pkg.sv
// Shared definitions for the TinyMIPS multicycle controller: opcodes, funct
// codes, ALU control words, ALU-op classes and the controller state encoding.
// Optional feature macro: TINYMIPS_ADDI_EN (adds the addi execute/writeback states).
package tinymips_pkg;

  // Instruction opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type function fields
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU control words
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation class requested by the controller
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Controller states; the addi states sit at the end so they can drop out cleanly
  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12
`ifdef TINYMIPS_ADDI_EN
    ,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
`endif
  } state_t;

endpackage

// File: rtl/mips_controller_aludec.sv
// ALU decoder: maps the controller's ALU-op class and the R-type funct field
// onto the 3-bit ALU control word. Purely combinational.
module aludec
  import tinymips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);

  // Select ALU control from op class, falling back to add for anything unknown
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucont = ALU_ADD;
          FUNCT_SUB: alucont = ALU_SUB;
          FUNCT_AND: alucont = ALU_AND;
          FUNCT_OR:  alucont = ALU_OR;
          FUNCT_SLT: alucont = ALU_SLT;
          default:   alucont = ALU_ADD;
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle Moore control unit for the 8-bit TinyMIPS datapath. Sequences
// four byte fetches, decode, execute, memory and writeback, and drives every
// datapath enable/select plus the ALU control word.
// Optional feature macro: TINYMIPS_ADDI_EN (decode addi; otherwise it is a NOP).
module mips_controller
  import tinymips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic [3:0] irwrite,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic [2:0] alucont
);

  state_t state;
  state_t next_state;
  aluop_t aluop;
  logic   pcwrite;
  logic   branch;

  // State register with synchronous reset back to the first fetch cycle
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) state <= FETCH1;
    else       state <= next_state;
  end

  // Next-state and Moore outputs; reset holds every strobe and select at zero
  always_comb begin
    next_state = FETCH1;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    irwrite    = 4'b0000;
    pcsource   = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    aluop      = ALUOP_ADD;
    if (!reset) begin
      case (state)
        FETCH1: begin
          memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0001;
          next_state = FETCH2;
        end
        FETCH2: begin
          memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0010;
          next_state = FETCH3;
        end
        FETCH3: begin
          memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0100;
          next_state = FETCH4;
        end
        FETCH4: begin
          memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b1000;
          next_state = DECODE;
        end
        DECODE: begin
          // Precompute the branch target while the opcode is examined
          alusrcb = 2'b11;
          case (op)
            OP_LB, OP_SB: next_state = MEMADR;
            OP_RTYPE:     next_state = RTYPEEX;
            OP_BEQ:       next_state = BEQEX;
            OP_J:         next_state = JEX;
`ifdef TINYMIPS_ADDI_EN
            OP_ADDI:      next_state = ADDIEX;
`endif
            default:      next_state = FETCH1;  // illegal opcode retires as a NOP
          endcase
        end
        MEMADR: begin
          alusrca = 1'b1; alusrcb = 2'b10;
          next_state = (op == OP_SB) ? SBWR : LBRD;
        end
        LBRD: begin
          memread = 1'b1; iord = 1'b1;
          next_state = LBWR;
        end
        LBWR: begin
          regwrite = 1'b1; memtoreg = 1'b1;
          next_state = FETCH1;
        end
        SBWR: begin
          memwrite = 1'b1; iord = 1'b1;
          next_state = FETCH1;
        end
        RTYPEEX: begin
          alusrca = 1'b1; aluop = ALUOP_FUNCT;
          next_state = RTYPEWR;
        end
        RTYPEWR: begin
          regdst = 1'b1; regwrite = 1'b1;
          next_state = FETCH1;
        end
        BEQEX: begin
          alusrca = 1'b1; aluop = ALUOP_SUB; pcsource = 2'b01; branch = 1'b1;
          next_state = FETCH1;
        end
        JEX: begin
          pcsource = 2'b10; pcwrite = 1'b1;
          next_state = FETCH1;
        end
`ifdef TINYMIPS_ADDI_EN
        ADDIEX: begin
          alusrca = 1'b1; alusrcb = 2'b10;
          next_state = ADDIWR;
        end
        ADDIWR: begin
          regwrite = 1'b1;
          next_state = FETCH1;
        end
`endif
        default: next_state = FETCH1;
      endcase
    end
  end

  // PC loads unconditionally on pcwrite, or on a taken branch
  assign pcen = pcwrite | (branch & zero);

  aludec u_aludec (
    .aluop   (aluop),
    .funct   (funct),
    .alucont (alucont)
  );

endmodule

// File: tb/tb_mips_controller.sv
// Directed testbench for mips_controller: walks each instruction class
// through its state sequence and compares the full output word per cycle
// against hand-derived values. Outputs are sampled 1 ns after the rising edge.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, iord, alusrca, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [2:0] alucont;

  int total = 0;
  int bad   = 0;

  mips_controller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .memread  (memread),
    .memwrite (memwrite),
    .iord     (iord),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .regwrite (regwrite),
    .irwrite  (irwrite),
    .pcsource (pcsource),
    .pcen     (pcen),
    .alucont  (alucont)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Output word layout: memread memwrite iord alusrca alusrcb memtoreg regdst
  // regwrite irwrite pcsource pcen alucont (19 bits)
  function automatic logic [31:0] mk(input logic mr, input logic mw, input logic io,
                                     input logic sa, input logic [1:0] sb,
                                     input logic mtr, input logic rd, input logic rw,
                                     input logic [3:0] ir, input logic [1:0] ps,
                                     input logic pe, input logic [2:0] ac);
    return {13'd0, mr, mw, io, sa, sb, mtr, rd, rw, ir, ps, pe, ac};
  endfunction

  function automatic logic [31:0] outs();
    return {13'd0, memread, memwrite, iord, alusrca, alusrcb, memtoreg, regdst,
            regwrite, irwrite, pcsource, pcen, alucont};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v_rst, v_f1, v_f2, v_f3, v_f4, v_dec, v_rex, v_rwr, v_madr, v_lbrd,
               v_lbwr, v_sbwr, v_beq1, v_beq0, v_jex, v_aex, v_awr;
  logic [5:0]  ftab [6];
  logic [2:0]  atab [6];

  // Checks FETCH1..FETCH4 and DECODE, leaving the DUT in DECODE
  task automatic fetch_decode(input string tag);
    check({tag, ".f1"}, outs(), v_f1);  step();
    check({tag, ".f2"}, outs(), v_f2);  step();
    check({tag, ".f3"}, outs(), v_f3);  step();
    check({tag, ".f4"}, outs(), v_f4);  step();
    check({tag, ".dec"}, outs(), v_dec);
  endtask

  initial begin
    v_rst  = mk(0,0,0,0,2'b00,0,0,0,4'b0000,2'b00,0,3'b010);
    v_f1   = mk(1,0,0,0,2'b01,0,0,0,4'b0001,2'b00,1,3'b010);
    v_f2   = mk(1,0,0,0,2'b01,0,0,0,4'b0010,2'b00,1,3'b010);
    v_f3   = mk(1,0,0,0,2'b01,0,0,0,4'b0100,2'b00,1,3'b010);
    v_f4   = mk(1,0,0,0,2'b01,0,0,0,4'b1000,2'b00,1,3'b010);
    v_dec  = mk(0,0,0,0,2'b11,0,0,0,4'b0000,2'b00,0,3'b010);
    v_rex  = mk(0,0,0,1,2'b00,0,0,0,4'b0000,2'b00,0,3'b111);
    v_rwr  = mk(0,0,0,0,2'b00,0,1,1,4'b0000,2'b00,0,3'b010);
    v_madr = mk(0,0,0,1,2'b10,0,0,0,4'b0000,2'b00,0,3'b010);
    v_lbrd = mk(1,0,1,0,2'b00,0,0,0,4'b0000,2'b00,0,3'b010);
    v_lbwr = mk(0,0,0,0,2'b00,1,0,1,4'b0000,2'b00,0,3'b010);
    v_sbwr = mk(0,1,1,0,2'b00,0,0,0,4'b0000,2'b00,0,3'b010);
    v_beq1 = mk(0,0,0,1,2'b00,0,0,0,4'b0000,2'b01,1,3'b110);
    v_beq0 = mk(0,0,0,1,2'b00,0,0,0,4'b0000,2'b01,0,3'b110);
    v_jex  = mk(0,0,0,0,2'b00,0,0,0,4'b0000,2'b10,1,3'b010);
    v_aex  = mk(0,0,0,1,2'b10,0,0,0,4'b0000,2'b00,0,3'b010);
    v_awr  = mk(0,0,0,0,2'b00,0,0,1,4'b0000,2'b00,0,3'b010);
    ftab[0] = 6'b100000; atab[0] = 3'b010;
    ftab[1] = 6'b100010; atab[1] = 3'b110;
    ftab[2] = 6'b100100; atab[2] = 3'b000;
    ftab[3] = 6'b100101; atab[3] = 3'b001;
    ftab[4] = 6'b101010; atab[4] = 3'b111;
    ftab[5] = 6'b111111; atab[5] = 3'b010;

    // Reset: outputs forced quiet even with zero high
    reset = 1'b1; op = 6'b111111; funct = 6'b000000; zero = 1'b1;
    step(); step();
    check("reset.outs", outs(), v_rst);

    // Release, fetch sequence, illegal opcode returns straight to FETCH1 (5 cycles)
    reset = 1'b0; zero = 1'b0; #1;
    fetch_decode("illegal");
    step();
    check("illegal.back_f1", outs(), v_f1);

    // R-type slt, plus every funct mapping while parked in RTYPEEX (7 cycles)
    op = 6'b000000; funct = 6'b101010;
    fetch_decode("rtype");
    step();
    check("rtype.ex", outs(), v_rex);
    for (int i = 0; i < 6; i++) begin
      funct = ftab[i]; #1;
      check($sformatf("rtype.funct%0d", i), {29'd0, alucont}, {29'd0, atab[i]});
    end
    funct = 6'b101010; #1;
    step();
    check("rtype.wr", outs(), v_rwr);
    step();
    check("rtype.back_f1", outs(), v_f1);

    // lb (8 cycles)
    op = 6'b100000;
    fetch_decode("lb");
    step(); check("lb.memadr", outs(), v_madr);
    step(); check("lb.rd", outs(), v_lbrd);
    step(); check("lb.wr", outs(), v_lbwr);
    step(); check("lb.back_f1", outs(), v_f1);

    // beq taken (6 cycles)
    op = 6'b000100; zero = 1'b1;
    fetch_decode("beq1");
    step(); check("beq1.ex", outs(), v_beq1);
    step(); check("beq1.back_f1", outs(), v_f1);

    // beq not taken
    zero = 1'b0;
    fetch_decode("beq0");
    step(); check("beq0.ex", outs(), v_beq0);
    step(); check("beq0.back_f1", outs(), v_f1);

    // j (6 cycles)
    op = 6'b000010;
    fetch_decode("j");
    step(); check("j.ex", outs(), v_jex);
    step(); check("j.back_f1", outs(), v_f1);

    // addi: real execute path when enabled, NOP otherwise
    op = 6'b001000;
    fetch_decode("addi");
    step();
`ifdef TINYMIPS_ADDI_EN
    check("addi.ex", outs(), v_aex);
    step(); check("addi.wr", outs(), v_awr);
    step(); check("addi.back_f1", outs(), v_f1);
`else
    check("addi.nop_f1", outs(), v_f1);
`endif

    // sb aborted by reset during SBWR
    op = 6'b101000;
    fetch_decode("sb");
    step(); check("sb.memadr", outs(), v_madr);
    step(); check("sb.wr", outs(), v_sbwr);
    reset = 1'b1; #1;
    check("sb.reset_in_wr", outs(), v_rst);
    step();
    check("sb.reset_held", outs(), v_rst);
    reset = 1'b0; #1;
    check("sb.after_reset_f1", outs(), v_f1);
    step();
    check("sb.after_reset_f2", outs(), v_f2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
